// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready handshakes on both sides.
// Define IF_ID_SKID_EN for a two-entry skid buffer with registered in_ready; default is a single entry.
module if_id_stage_reg #(
    parameter int unsigned        ADDR_W    = 64,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instruction,
    input  logic [ADDR_W-1:0]  in_address,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [ADDR_W-1:0]  out_address,
    output logic [ADDR_W-1:0]  out_pc_plus4
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_out_valid;
    logic               w_load_head;
    logic [INSTR_W-1:0] r_head_instr;
    logic [ADDR_W-1:0]  r_head_addr;

    assign w_out_valid = (r_state != EMPTY);
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_in_fire   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef IF_ID_SKID_EN

    logic               w_load_tail;
    logic               w_promote;
    logic               r_can_accept;
    logic [INSTR_W-1:0] r_tail_instr;
    logic [ADDR_W-1:0]  r_tail_addr;

    // Registered accept flag tracks the next state so in_ready never sees out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_can_accept <= 1'b1;
        end else begin
            r_can_accept <= (w_state_nxt != TWO);
        end
    end

    assign in_ready = rst_n & r_can_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_promote   = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_load_head = 1'b1;
                    end
                end
                ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b10: begin
                            w_state_nxt = TWO;
                            w_load_tail = 1'b1;
                        end
                        2'b01: w_state_nxt = EMPTY;
                        2'b11: w_load_head = 1'b1;
                        default: w_state_nxt = ONE;
                    endcase
                end
                TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_promote   = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_instr <= NOP_INSTR;
            r_head_addr  <= '0;
            r_tail_instr <= NOP_INSTR;
            r_tail_addr  <= '0;
        end else begin
            if (w_load_head) begin
                r_head_instr <= in_instruction;
                r_head_addr  <= in_address;
            end else if (w_promote) begin
                r_head_instr <= r_tail_instr;
                r_head_addr  <= r_tail_addr;
            end
            if (w_load_tail) begin
                r_tail_instr <= in_instruction;
                r_tail_addr  <= in_address;
            end
        end
    end

`else

    // Simultaneous drain and fill overwrite the entry in place, so no bubble.
    assign in_ready = rst_n & (~w_out_valid | out_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_load_head = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire) begin
                        w_load_head = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_instr <= NOP_INSTR;
            r_head_addr  <= '0;
        end else if (w_load_head) begin
            r_head_instr <= in_instruction;
            r_head_addr  <= in_address;
        end
    end

`endif

    assign out_valid       = w_out_valid;
    assign out_instruction = w_out_valid ? r_head_instr : NOP_INSTR;
    assign out_address     = r_head_addr;
    assign out_pc_plus4    = r_head_addr + ADDR_W'(4);

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: vector table, directed corner sequences, random traffic vs a queue model.
// Honours IF_ID_SKID_EN to select the expected buffer depth.
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [63:0] in_address;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_address;
    logic [63:0] out_pc_plus4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    if_id_stage_reg #(
        .ADDR_W    (64),
        .INSTR_W   (32),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_address      (in_address),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_address     (out_address),
        .out_pc_plus4    (out_pc_plus4)
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO bounded by the configured depth.
    typedef struct {
        logic [31:0] ins;
        logic [63:0] addr;
    } ent_t;
    ent_t q[$];
    bit   m_addr_reset;

`ifdef IF_ID_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    function automatic logic m_in_ready();
        if (!rst_n) return 1'b0;
        if (DEPTH == 2) return (q.size() < 2);
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic v;
        v = (q.size() > 0);
        chk("model_out_valid", {63'd0, out_valid}, {63'd0, v});
        chk("model_in_ready", {63'd0, in_ready}, {63'd0, m_in_ready()});
        chk("model_out_instruction", {32'd0, out_instruction}, {32'd0, (v ? q[0].ins : NOP)});
        if (v) begin
            chk("model_out_address", out_address, q[0].addr);
            chk("model_out_pc_plus4", out_pc_plus4, q[0].addr + 64'd4);
        end else if (m_addr_reset) begin
            chk("model_reset_address", out_address, 64'd0);
            chk("model_reset_pc_plus4", out_pc_plus4, 64'd4);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] a,
                         input logic f, input logic r);
        @(negedge clk);
        in_valid       = v;
        in_instruction = ins;
        in_address     = a;
        flush          = f;
        out_ready      = r;
        #1;
        check_model();
    endtask

    task automatic edge_step();
        logic in_fire, out_fire;
        in_fire  = in_valid && m_in_ready();
        out_fire = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                q.delete();
                m_addr_reset = 0;
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) begin
                    q.push_back('{in_instruction, in_address});
                    m_addr_reset = 0;
                end
            end
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [63:0] addr;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ea;
        logic [63:0] epc;
        logic        ca;
    } vec_t;
    vec_t tbl[6];

    initial begin
        // Stream with out_ready=1: 1-cycle latency, no bubbles, and address wrap.
        tbl[0] = '{1'b1, 32'h00100093, 64'h0,                  1'b0, NOP,          64'h0,                  64'h4, 1'b1};
        tbl[1] = '{1'b1, 32'h00200113, 64'h4,                  1'b1, 32'h00100093, 64'h0,                  64'h4, 1'b1};
        tbl[2] = '{1'b1, 32'h00300193, 64'h8,                  1'b1, 32'h00200113, 64'h4,                  64'h8, 1'b1};
        tbl[3] = '{1'b1, 32'h00400213, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h00300193, 64'h8,                  64'hC, 1'b1};
        tbl[4] = '{1'b0, 32'hDEADBEEF, 64'h55,                 1'b1, 32'h00400213, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1};
        tbl[5] = '{1'b0, 32'hDEADBEEF, 64'h55,                 1'b0, NOP,          64'h0,                  64'h0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instruction = '0; in_address = '0;
        flush = 1'b0; out_ready = 1'b0;
        m_addr_reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].iv, tbl[i].ins, tbl[i].addr, 1'b0, 1'b1);
            chk("tbl_out_valid", {63'd0, out_valid}, {63'd0, tbl[i].ev});
            chk("tbl_in_ready", {63'd0, in_ready}, 64'd1);
            chk("tbl_out_instruction", {32'd0, out_instruction}, {32'd0, tbl[i].ei});
            if (tbl[i].ca) begin
                chk("tbl_out_address", out_address, tbl[i].ea);
                chk("tbl_out_pc_plus4", out_pc_plus4, tbl[i].epc);
            end
            edge_step();
        end

        // Flush beats a simultaneous input transfer.
        drive(1'b1, 32'h0000_0200, 64'h200, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 32'h0000_0204, 64'h204, 1'b1, 1'b0);
        chk("flush_held_addr", out_address, 64'h200);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
            chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
            chk("flush_out_instruction", {32'd0, out_instruction}, {32'd0, NOP});
            edge_step();
        end

`ifdef IF_ID_SKID_EN
        drive(1'b1, 32'h0000_0100, 64'h100, 1'b0, 1'b0);
        chk("bp_in_ready0", {63'd0, in_ready}, 64'd1);
        edge_step();
        drive(1'b1, 32'h0000_0104, 64'h104, 1'b0, 1'b0);
        chk("bp_in_ready1", {63'd0, in_ready}, 64'd1);
        chk("bp_addr1", out_address, 64'h100);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_addr", out_address, 64'h100);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        chk("bp_first_out", out_address, 64'h100);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        chk("bp_second_out", out_address, 64'h104);
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        edge_step();
`else
        drive(1'b1, 32'h0000_0300, 64'h300, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 32'h0000_0304, 64'h304, 1'b0, 1'b1);
        chk("repl_in_ready", {63'd0, in_ready}, 64'd1);
        chk("repl_old_addr", out_address, 64'h300);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        chk("repl_out_valid", {63'd0, out_valid}, 64'd1);
        chk("repl_new_addr", out_address, 64'h304);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        edge_step();
`endif

        // Asynchronous reset while holding an entry.
        drive(1'b1, 32'h0000_0400, 64'h400, 1'b0, 1'b0);
        edge_step();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        q.delete();
        m_addr_reset = 1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instruction", {32'd0, out_instruction}, {32'd0, NOP});
        chk("rst_out_address", out_address, 64'd0);
        chk("rst_out_pc_plus4", out_pc_plus4, 64'd4);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        edge_step();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_0500, 64'h500, 1'b0, 1'b1);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        edge_step();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        chk("post_rst_addr", out_address, 64'h500);
        edge_step();

        for (int i = 0; i < 1500; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFFC;
            drive($urandom_range(0, 3) != 0, $urandom, a,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
IF_ID_STAGE_REG -- requirements
Module: if_id_stage_reg

Interface
REQ-001 Parameter ADDR_W, default 64: instruction address width.
REQ-002 Parameter INSTR_W, default 32: instruction width.
REQ-003 Parameter NOP_INSTR, default 32'h00000013: value driven on out_instruction when no valid entry is held.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  fetch stage presents a valid instruction.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_instruction  input  INSTR_W  fetched instruction.
REQ-009 in_address  input  ADDR_W  address of the fetched instruction.
REQ-010 flush  input  1  discard all held and incoming entries (taken branch/jump).
REQ-011 out_valid  output  1  decode stage is presented a valid instruction.
REQ-012 out_ready  input  1  decode stage consumes the presented instruction this cycle.
REQ-013 out_instruction  output  INSTR_W  held instruction, NOP_INSTR when out_valid=0.
REQ-014 out_address  output  ADDR_W  address of held instruction.
REQ-015 out_pc_plus4  output  ADDR_W  out_address + 4.

Function
REQ-016 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Latency: an accepted instruction appears on out_valid/out_instruction/out_address exactly 1 cycle after acceptance when the block was empty.
REQ-018 Ordering is strict FIFO; no instruction is duplicated or lost except by flush.
REQ-019 While out_valid=1 and out_ready=0, out_instruction, out_address and out_pc_plus4 are held stable.
REQ-020 out_pc_plus4 is computed modulo 2^ADDR_W; out_address all-ones minus 3 yields 0.
REQ-021 flush=1 at an edge has highest priority: all entries invalidated, any simultaneous input transfer discarded, out_valid=0 next cycle, out_instruction=NOP_INSTR.
REQ-022 flush has no effect on out_address/out_pc_plus4 beyond marking them invalid; values are don't-care while out_valid=0.
REQ-023 Inputs in_instruction/in_address are ignored when in_valid=0.

Reset
REQ-024 rst_n=0 immediately, without clk, forces out_valid=0, out_instruction=NOP_INSTR, out_address=0, out_pc_plus4=4, all entries invalid, FSM state EMPTY.
REQ-025 in_ready=0 while rst_n=0; first acceptance possible on the first rising edge after rst_n deasserts.
REQ-026 Reset asserted mid-transfer discards all held entries; no partial state survives.

Configuration
REQ-027 Macro IF_ID_SKID_EN selects buffer depth.
REQ-028 With IF_ID_SKID_EN defined: two-entry skid buffer, FSM states EMPTY, ONE, TWO; in_ready is a register output equal to (state != TWO), with no combinational path from out_ready.
REQ-029 Skid transitions: EMPTY+in -> ONE; ONE+in only -> TWO; ONE+out only -> EMPTY; ONE+in+out -> ONE holding new entry; TWO+out -> ONE with second entry promoted; TWO never accepts; flush from any state -> EMPTY.
REQ-030 Without IF_ID_SKID_EN: single-entry register; in_ready = rst_n & (!out_valid | out_ready) combinationally; simultaneous input and output transfer replaces the entry with no bubble.

Verification
REQ-031 Reset: rst_n=0 mid-run -> out_valid=0, out_instruction=0x00000013, out_address=0, out_pc_plus4=4 before next clk edge.
REQ-032 Stream: in_valid=1, out_ready=1, addresses 0x0,0x4,0x8 -> out_address 0x0,0x4,0x8 on consecutive cycles, 1-cycle latency, no bubbles.
REQ-033 Backpressure (skid on): accept 0x100 and 0x104 with out_ready=0 -> in_ready=0 next cycle, out_address holds 0x100; release out_ready -> 0x100 then 0x104 in order.
REQ-034 Flush: held 0x200, in_valid=1 with 0x204, flush=1 same edge -> out_valid=0 next cycle, 0x204 never appears.
REQ-035 Wrap: in_address=0xFFFFFFFFFFFFFFFC -> out_pc_plus4=0x0.
REQ-036 Non-skid build: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, entry replaced, out_valid stays 1.
